// File: rtl/sigmoid_issue_sched_if.sv
// Sigmoid pipeline side of the issue scheduler.
// master: scheduler (drives issue strobe/word_sel/index, receives results).
// slave:  sigmoid pipeline.
interface sigmoid_issue_sched_if;
    logic       sig_reg_wen;
    logic [3:0] sig_word_sel;
    logic [4:0] sig_index;
    logic       sig_reg_wen_o;
    logic [3:0] sig_error;
    logic       sig_empty;

    modport master (
        output sig_reg_wen, sig_word_sel, sig_index,
        input  sig_reg_wen_o, sig_error, sig_empty
    );

    modport slave (
        input  sig_reg_wen, sig_word_sel, sig_index,
        output sig_reg_wen_o, sig_error, sig_empty
    );
endinterface

// File: rtl/sigmoid_issue_sched.sv
// Issue sequencer for the 4-lane sigmoid pipeline: one job at a time, one
// 4-lane group per cycle, throttled by downstream writeback credits.
// Optional macro SIGMOID_SCHED_TIMEOUT_EN adds a drain watchdog and the
// 'timeout' output (and the SIG_LAT parameter that sizes the watchdog).
module sigmoid_issue_sched #(
    parameter int unsigned CREDITS = 8
`ifdef SIGMOID_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned SIG_LAT = 30
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [8:0]                   num_groups,
    input  logic [4:0]                   base_index,
    input  logic                         credit_return,
    sigmoid_issue_sched_if.master        sig,
    output logic                         busy,
    output logic                         done,
    output logic [3:0]                   err_flags,
    output logic [3:0]                   credits_avail
`ifdef SIGMOID_SCHED_TIMEOUT_EN
    ,
    output logic                         timeout
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    state_t     state_q, state_d;
    logic [8:0] ng_q, ng_d;
    logic [4:0] base_q, base_d;
    logic [8:0] issued_q, issued_d;
    logic [8:0] returned_q, returned_d;
    logic [3:0] credits_q, credits_d;
    logic [3:0] err_q, err_d;
    logic       wen_q, wen_d;
    logic [3:0] wsel_q, wsel_d;
    logic [4:0] idx_q, idx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       accept;
    logic       fire;
    logic [8:0] cur_ng;
    logic [4:0] cur_base;
    logic [8:0] cur_issued;

`ifdef SIGMOID_SCHED_TIMEOUT_EN
    localparam logic [15:0] WD_LIMIT = 16'(SIG_LAT + 16);
    logic [15:0] wd_q, wd_d;
    logic        to_q, to_d;
`endif

    // Next-state, issue decision, credit/return bookkeeping.
    // The issue decision is also evaluated in the IDLE start cycle (using the
    // live inputs) so the first registered strobe appears the cycle after start.
    always_comb begin
        state_d    = state_q;
        ng_d       = ng_q;
        base_d     = base_q;
        issued_d   = issued_q;
        returned_d = returned_q;
        credits_d  = credits_q;
        err_d      = err_q;
        wen_d      = 1'b0;
        wsel_d     = wsel_q;
        idx_d      = idx_q;
`ifdef SIGMOID_SCHED_TIMEOUT_EN
        wd_d       = '0;
        to_d       = to_q;
`endif

        accept     = (state_q == IDLE) && start;
        cur_ng     = accept ? num_groups : ng_q;
        cur_base   = accept ? base_index : base_q;
        cur_issued = accept ? '0 : issued_q;
        fire       = (accept || (state_q == ISSUE)) && (cur_issued < cur_ng) &&
                     ((credits_q != '0) || credit_return);

        if (fire && !credit_return) begin
            credits_d = credits_q - 4'd1;
        end else if (!fire && credit_return && (credits_q != CRED_MAX)) begin
            credits_d = credits_q + 4'd1;
        end

        if (fire) begin
            wen_d    = 1'b1;
            wsel_d   = cur_issued[3:0];
            idx_d    = cur_base + cur_issued[8:4];
            issued_d = cur_issued + 9'd1;
        end

        if (((state_q == ISSUE) || (state_q == DRAIN)) && sig.sig_reg_wen_o) begin
            returned_d = returned_q + 9'd1;
            err_d      = err_q | sig.sig_error;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ng_d       = num_groups;
                    base_d     = base_index;
                    err_d      = '0;
                    returned_d = '0;
`ifdef SIGMOID_SCHED_TIMEOUT_EN
                    to_d       = 1'b0;
`endif
                    if (!fire) begin
                        issued_d = '0;
                    end
                    if (num_groups == '0) begin
                        state_d = DONE;
                    end else if (fire && (num_groups == 9'd1)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (fire && (issued_d == ng_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
`ifdef SIGMOID_SCHED_TIMEOUT_EN
                wd_d = sig.sig_reg_wen_o ? '0 : wd_q + 16'd1;
`endif
                if ((returned_q == ng_q) && sig.sig_empty) begin
                    state_d = DONE;
`ifdef SIGMOID_SCHED_TIMEOUT_EN
                end else if (!sig.sig_reg_wen_o && (wd_q + 16'd1 == WD_LIMIT)) begin
                    state_d = DONE;
                    to_d    = 1'b1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ng_q       <= '0;
            base_q     <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            credits_q  <= CRED_MAX;
            err_q      <= '0;
            wen_q      <= 1'b0;
            wsel_q     <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SIGMOID_SCHED_TIMEOUT_EN
            wd_q       <= '0;
            to_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ng_q       <= ng_d;
            base_q     <= base_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            credits_q  <= credits_d;
            err_q      <= err_d;
            wen_q      <= wen_d;
            wsel_q     <= wsel_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SIGMOID_SCHED_TIMEOUT_EN
            wd_q       <= wd_d;
            to_q       <= to_d;
`endif
        end
    end

    assign sig.sig_reg_wen  = wen_q;
    assign sig.sig_word_sel = wsel_q;
    assign sig.sig_index    = idx_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err_flags        = err_q;
    assign credits_avail    = credits_q;
`ifdef SIGMOID_SCHED_TIMEOUT_EN
    assign timeout          = to_q;
`endif

endmodule
